// File: rtl/dds_uart_pkg.sv
// dds_uart_pkg: definitions shared by the DDS control-link UART blocks
// (uart_rx and uart_tx).
//   uart_state_e      : transmitter FSM state encoding
//   UART_*_LVL        : line levels for the start bit, the stop bit and idle
//   DATA_BITS         : data bits per frame
//   FRAME_BITS        : start + byte index + data + stop
//   BYTES_PER_WORD    : bytes in one 16-bit frequency word
//   DEFAULT_CLKS_PER_BIT : 115200 baud at 60 MHz
package dds_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_BIT = 3'd1,
        ST_IDX_BIT   = 3'd2,
        ST_DATA_BITS = 3'd3,
        ST_STOP_BIT  = 3'd4,
        ST_DONE      = 3'd5
    } uart_state_e;

    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
    localparam logic UART_IDLE_LVL  = 1'b1;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 11;
    localparam int BYTES_PER_WORD       = 2;
    localparam int DEFAULT_CLKS_PER_BIT = 521;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter.
//   clk, rst : clock and synchronous active-high reset
//   clear    : hold the counter at 0 (used while the line is not shifting)
//   bit_end  : high during the last cycle of each bit period
// The counter runs 0..CLKS_PER_BIT-1 and wraps, so each bit lasts exactly
// CLKS_PER_BIT cycles counted from the cycle after clear is released.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 521,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: reports the selected 16-bit DDS frequency word back to the host
// as two back-to-back 11-bit frames (low byte, then high byte).
// Frame: start(0), byte index (0 low / 1 high), 8 data bits LSB first, stop(1).
//   clk, rst  : clock and synchronous active-high reset
//   start     : one-cycle request; accepted only in IDLE, otherwise dropped
//               (no queueing). There is no ready signal: the requester may
//               watch busy, and a start seen while busy is simply ignored.
//   freq_sel  : 0 selects freq0, 1 selects freq1; sampled on acceptance
//   freq0/1   : frequency words
//   tx        : serial line, idles high, registered
//   busy      : high from the cycle after acceptance through the done cycle
//   done      : one-cycle pulse after the high-byte stop bit
module uart_tx
    import dds_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        freq_sel,
    input  logic [15:0] freq0,
    input  logic [15:0] freq1,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e state_q, state_n;
    logic        byte_q, byte_n;
    logic [2:0]  bit_q, bit_n;
    logic [15:0] shadow_q, shadow_n;
    logic        tx_n, busy_n, done_n;
    logic        timer_clear;
    logic        bit_end;

    // Counter sits at 0 outside the frame so the first bit after acceptance
    // gets a full period.
    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            byte_q   <= 1'b0;
            bit_q    <= '0;
            shadow_q <= '0;
            tx       <= UART_IDLE_LVL;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_n;
            byte_q   <= byte_n;
            bit_q    <= bit_n;
            shadow_q <= shadow_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next state, indices and shadow word.
    always_comb begin
        state_n  = state_q;
        byte_n   = byte_q;
        bit_n    = bit_q;
        shadow_n = shadow_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_START_BIT;
                    byte_n   = 1'b0;
                    bit_n    = '0;
                    shadow_n = freq_sel ? freq1 : freq0;
                end
            end
            ST_START_BIT: begin
                if (bit_end) state_n = ST_IDX_BIT;
            end
            ST_IDX_BIT: begin
                if (bit_end) begin
                    state_n = ST_DATA_BITS;
                    bit_n   = '0;
                end
            end
            ST_DATA_BITS: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_n = ST_STOP_BIT;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end
            end
            ST_STOP_BIT: begin
                if (bit_end) begin
                    if (!byte_q) begin
                        byte_n  = 1'b1;
                        state_n = ST_START_BIT;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                byte_n  = 1'b0;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so tx/busy/done can be
    // registered without adding a cycle of latency.
    always_comb begin
        tx_n   = UART_IDLE_LVL;
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_DONE);
        unique case (state_n)
            ST_START_BIT: tx_n = UART_START_LVL;
            ST_IDX_BIT:   tx_n = byte_n;
            ST_DATA_BITS: tx_n = shadow_n[{byte_n, bit_n}];
            ST_STOP_BIT:  tx_n = UART_STOP_LVL;
            default:      tx_n = UART_IDLE_LVL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLKS_PER_BIT = 8.
// Cycle numbering: cycle 1 is the cycle following the edge that samples start.
module tb_uart_tx;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        freq_sel = 1'b0;
    logic [15:0] freq0 = '0;
    logic [15:0] freq1 = '0;
    logic        tx, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .freq_sel (freq_sel),
        .freq0    (freq0),
        .freq1    (freq1),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Sends one word and checks tx/busy/done every cycle through cycle 182.
    // bits: the 22 line bits in transmit order, first bit in bit 21.
    // rst_at: cycle during which rst is held high (0 = none).
    // stress: change freq0/freq_sel mid-frame and pulse start at 50, 100, 177.
    task automatic send(input string name, input logic sel, input logic [15:0] f0,
                        input logic [15:0] f1, input logic [21:0] bits,
                        input int rst_at, input bit stress);
        freq_sel = sel;
        freq0    = f0;
        freq1    = f1;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 182; cyc++) begin
            if (rst_at > 0 && cyc > rst_at) begin
                chk({name, "_rst_tx"},   cyc, tx,   1'b1);
                chk({name, "_rst_busy"}, cyc, busy, 1'b0);
                chk({name, "_rst_done"}, cyc, done, 1'b0);
            end else if (cyc <= 176) begin
                chk({name, "_tx"},   cyc, tx,   bits[21 - (cyc - 1) / CPB]);
                chk({name, "_busy"}, cyc, busy, 1'b1);
                chk({name, "_done"}, cyc, done, 1'b0);
            end else if (cyc == 177) begin
                chk({name, "_done_tx"},   cyc, tx,   1'b1);
                chk({name, "_done_busy"}, cyc, busy, 1'b1);
                chk({name, "_done_pulse"}, cyc, done, 1'b1);
            end else begin
                chk({name, "_idle_tx"},   cyc, tx,   1'b1);
                chk({name, "_idle_busy"}, cyc, busy, 1'b0);
                chk({name, "_idle_done"}, cyc, done, 1'b0);
            end
            rst = (cyc == rst_at);
            if (stress) begin
                if (cyc == 40) freq0 = 16'hFFFF;
                if (cyc == 60) begin
                    freq_sel = ~sel;
                    freq1    = 16'h0F0F;
                end
                start = (cyc == 50) || (cyc == 100) || (cyc == 177);
            end
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        // Reset held for 3 cycles, then 20 idle cycles.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_tx",   i, tx,   1'b1);
            chk("reset_busy", i, busy, 1'b0);
            chk("reset_done", i, done, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_tx",   i, tx,   1'b1);
            chk("idle_busy", i, busy, 1'b0);
            chk("idle_done", i, done, 1'b0);
        end

        // 0xA55A from freq0.
        send("a55a", 1'b0, 16'hA55A, 16'h0000,
             22'b00010110101_01101001011, 0, 1'b0);

        // 0x0001 from freq1; freq0 holds a decoy.
        send("f1_0001", 1'b1, 16'hFFFF, 16'h0001,
             22'b00100000001_01000000001, 0, 1'b0);

        // 0x1234 with freq0 -> 0xFFFF at cycle 40, freq_sel flipped at 60,
        // and start pulses at 50, 100 and 177 that must be ignored.
        send("hold_1234", 1'b0, 16'h1234, 16'hAAAA,
             22'b00001011001_01010010001, 0, 1'b1);

        // Reset during cycle 90 of a 0x1234 transfer.
        send("rst_mid", 1'b0, 16'h1234, 16'h0000,
             22'b00001011001_01010010001, 90, 1'b0);

        // Full frame after the abandoned one: 0x80C1 from freq1.
        send("after_rst", 1'b1, 16'h0000, 16'h80C1,
             22'b00100000111_01000000011, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
